// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard detection and pipeline control for the in-order core.
//
// A per-register latency counter marks results that are not yet forwardable. Only a
// consumer of such a register stalls. The unit also freezes the pipe while data memory
// is busy. It serialises CSR instructions with a drain/wait state machine. It drives the
// per-stage stall and flush vectors (index 0 = F/pc, 1 = D, 2 = E, 3 = M, 4 = W).
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   dec_valid             D holds a valid instruction
//   dec_rs1/2, _en        source register indices and their use flags
//   dec_rd, dec_wen       destination register and write enable
//   dec_lat               bubbles a dependent must wait for this result
//   dec_csr               serialising instruction in D
//   stage_valid           per-pipeline-register valid (non-bubble)
//   csr_commit            CSR instruction retiring in W
//   redirect              control-flow redirect resolved in E
//   trap                  exception / mret taken at W
//   imem_busy, dmem_busy  memory handshakes outstanding
//   stall, flush          per-register hold / load-bubble controls
//   issue                 D instruction enters E this cycle
//   sb_busy               register has a nonzero latency counter
module hazard_scoreboard #(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned NREG   = 32,
  parameter int unsigned LAT_W  = 3,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dec_valid,
  input  logic [AW-1:0]     dec_rs1,
  input  logic [AW-1:0]     dec_rs2,
  input  logic              dec_rs1_en,
  input  logic              dec_rs2_en,
  input  logic [AW-1:0]     dec_rd,
  input  logic              dec_wen,
  input  logic [LAT_W-1:0]  dec_lat,
  input  logic              dec_csr,
  input  logic [NSTAGE-1:0] stage_valid,
  input  logic              csr_commit,
  input  logic              redirect,
  input  logic              trap,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              issue,
  output logic [NREG-1:0]   sb_busy
);

  typedef enum logic [1:0] {StIdle, StDrain, StWait} csr_state_e;

  csr_state_e       state_q, state_d;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic any_busy;
  logic rs1_busy;
  logic rs2_busy;
  logic raw;
  logic drained;
  logic csr_hold;

  // F and D valid bits do not matter for draining.
  logic unused_stage_valid;
  assign unused_stage_valid = ^stage_valid[1:0];

  always_comb begin
    sb_busy = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      sb_busy[r] = (cnt_q[r] != '0);
    end
  end

  assign any_busy = |sb_busy;
  assign rs1_busy = dec_rs1_en && sb_busy[dec_rs1];
  assign rs2_busy = dec_rs2_en && sb_busy[dec_rs2];
  assign raw      = dec_valid && (rs1_busy || rs2_busy);
  assign drained  = (stage_valid[NSTAGE-1:2] == '0) && !any_busy;

  // A CSR seen in D while idle is held for the cycle it takes to enter DRAIN. It must
  // only issue from DRAIN once everything older has retired.
  assign csr_hold = (state_q == StIdle && dec_valid && dec_csr) ||
                    (state_q == StDrain && !drained);

  // Prioritised stall/flush generation.
  always_comb begin
    stall = '0;
    flush = '0;
    if (trap) begin
      flush = '1;
    end else if (dmem_busy) begin
      stall = '1;
    end else if (redirect) begin
      flush[1] = 1'b1;
      flush[2] = 1'b1;
    end else if (raw || csr_hold) begin
      stall[0] = 1'b1;
      stall[1] = 1'b1;
      flush[2] = 1'b1;
    end else if (state_q == StWait) begin
      stall[0] = 1'b1;
      flush[1] = 1'b1;
    end else if (imem_busy) begin
      stall[0] = 1'b1;
      flush[1] = 1'b1;
    end
  end

  assign issue = dec_valid && !stall[1] && !flush[2] && !trap;

  // CSR serialisation FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dec_valid && dec_csr) state_d = StDrain;
      // Issue in DRAIN implies drained, since csr_hold stalls D otherwise.
      StDrain: if (issue) state_d = StWait;
      StWait:  if (csr_commit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (trap) begin
      state_d = StIdle;
    end
  end

  // Latency counters: decrement-saturate, the issue write wins, trap clears, and
  // dmem_busy freezes.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      if (trap) begin
        cnt_d[r] = '0;
      end else begin
        if (!dmem_busy && cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        if (issue && dec_wen && dec_rd == AW'(r)) begin
          cnt_d[r] = dec_lat;
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        resetn;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_en, dec_rs2_en, dec_wen;
  logic [2:0]  dec_lat;
  logic        dec_csr;
  logic [4:0]  stage_valid;
  logic        csr_commit, redirect, trap, imem_busy, dmem_busy;
  logic [4:0]  stall, flush;
  logic        issue;
  logic [31:0] sb_busy;

  typedef struct {
    string       name;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        issue;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .resetn      (resetn),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rs1_en  (dec_rs1_en),
    .dec_rs2_en  (dec_rs2_en),
    .dec_rd      (dec_rd),
    .dec_wen     (dec_wen),
    .dec_lat     (dec_lat),
    .dec_csr     (dec_csr),
    .stage_valid (stage_valid),
    .csr_commit  (csr_commit),
    .redirect    (redirect),
    .trap        (trap),
    .imem_busy   (imem_busy),
    .dmem_busy   (dmem_busy),
    .stall       (stall),
    .flush       (flush),
    .issue       (issue),
    .sb_busy     (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the outputs are valid every cycle; compare mid-cycle against the queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall || flush !== e.flush || issue !== e.issue ||
          sb_busy !== e.busy) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b issue=%b busy=%h, want stall=%b flush=%b issue=%b busy=%h",
                 e.name, stall, flush, issue, sb_busy, e.stall, e.flush, e.issue, e.busy);
      end
    end
  end

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_en = 0; dec_rs2_en = 0;
    dec_rd = 0; dec_wen = 0; dec_lat = 0; dec_csr = 0; stage_valid = 0;
    csr_commit = 0; redirect = 0; trap = 0; imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic e1, input logic [4:0] rs2,
                       input logic e2, input logic [4:0] rd, input logic wen,
                       input logic [2:0] lat, input logic csr);
    dec_valid = 1; dec_rs1 = rs1; dec_rs1_en = e1; dec_rs2 = rs2; dec_rs2_en = e2;
    dec_rd = rd; dec_wen = wen; dec_lat = lat; dec_csr = csr;
  endtask

  // Queue the expected response for the inputs now applied, then advance one cycle.
  task automatic cyc(input string name, input logic [4:0] s, input logic [4:0] f,
                     input logic i, input logic [31:0] b);
    exp_t e;
    e.name = name; e.stall = s; e.flush = f; e.issue = i; e.busy = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] SRAW = 5'b00011;
  localparam logic [4:0] FRAW = 5'b00100;

  initial begin
    idle();
    resetn = 0;
    @(posedge clk);
    #1;
    cyc("reset", 5'b0, 5'b0, 1'b0, 32'h0);
    resetn = 1;
    cyc("idle", 5'b0, 5'b0, 1'b0, 32'h0);

    // Load-use: one bubble.
    set_d(5'd2, 1, 5'd0, 0, 5'd5, 1, 3'd1, 0);
    cyc("lu_load", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd5, 1, 5'd1, 1, 5'd6, 1, 3'd0, 0);
    cyc("lu_stall", SRAW, FRAW, 1'b0, 32'h20);
    cyc("lu_issue", 5'b0, 5'b0, 1'b1, 32'h0);
    idle();
    cyc("lu_after", 5'b0, 5'b0, 1'b0, 32'h0);

    // Lat-4 producer: four bubbles.
    set_d(5'd1, 1, 5'd2, 1, 5'd7, 1, 3'd4, 0);
    cyc("div_issue", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd7, 1, 5'd0, 0, 5'd3, 1, 3'd0, 0);
    for (int k = 0; k < 4; k++) cyc("div_stall", SRAW, FRAW, 1'b0, 32'h80);
    cyc("div_use", 5'b0, 5'b0, 1'b1, 32'h0);

    // x0 destination is never tracked; lat 0 never stalls.
    set_d(5'd1, 1, 5'd2, 1, 5'd0, 1, 3'd4, 0);
    cyc("x0_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd0, 1, 5'd0, 1, 5'd3, 1, 3'd0, 0);
    cyc("x0_use", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd1, 1, 5'd0, 0, 5'd8, 1, 3'd0, 0);
    cyc("lat0_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd8, 1, 5'd8, 1, 5'd3, 1, 3'd0, 0);
    cyc("lat0_use", 5'b0, 5'b0, 1'b1, 32'h0);

    // dmem_busy freezes a lat-2 counter; two bubbles remain afterwards.
    set_d(5'd1, 1, 5'd0, 0, 5'd9, 1, 3'd2, 0);
    cyc("mem_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd9, 1, 5'd0, 0, 5'd3, 1, 3'd0, 0);
    dmem_busy = 1;
    for (int k = 0; k < 3; k++) cyc("mem_freeze", 5'b11111, 5'b0, 1'b0, 32'h200);
    dmem_busy = 0;
    cyc("mem_bubble1", SRAW, FRAW, 1'b0, 32'h200);
    cyc("mem_bubble2", SRAW, FRAW, 1'b0, 32'h200);
    cyc("mem_use", 5'b0, 5'b0, 1'b1, 32'h0);

    // Priority: redirect over raw, then trap over dmem_busy.
    set_d(5'd1, 1, 5'd0, 0, 5'd10, 1, 3'd3, 0);
    cyc("pri_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd0, 0, 5'd10, 1, 5'd3, 1, 3'd0, 0);
    redirect = 1;
    cyc("pri_redirect", 5'b0, 5'b00110, 1'b0, 32'h400);
    redirect = 0; trap = 1; dmem_busy = 1;
    cyc("pri_trap", 5'b0, 5'b11111, 1'b0, 32'h400);
    idle();
    cyc("pri_cleared", 5'b0, 5'b0, 1'b0, 32'h0);

    // imem_busy only.
    imem_busy = 1;
    cyc("imem_idle", 5'b00001, 5'b00010, 1'b0, 32'h0);
    set_d(5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0);
    cyc("imem_issue", 5'b00001, 5'b00010, 1'b1, 32'h0);
    idle();

    // CSR drain: waits for E/M/W empty and all counters zero.
    stage_valid = 5'b11100;
    set_d(5'd1, 1, 5'd0, 0, 5'd11, 1, 3'd2, 0);
    cyc("csr_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 1);
    cyc("csr_enter", SRAW, FRAW, 1'b0, 32'h800);
    stage_valid = 5'b00000;
    cyc("csr_cnt_wait", SRAW, FRAW, 1'b0, 32'h800);
    stage_valid = 5'b11000;
    cyc("csr_pipe_wait", SRAW, FRAW, 1'b0, 32'h0);
    stage_valid = 5'b00011;
    cyc("csr_issue", 5'b0, 5'b0, 1'b1, 32'h0);
    idle();
    cyc("csr_wait1", 5'b00001, 5'b00010, 1'b0, 32'h0);
    cyc("csr_wait2", 5'b00001, 5'b00010, 1'b0, 32'h0);
    csr_commit = 1;
    cyc("csr_commit", 5'b00001, 5'b00010, 1'b0, 32'h0);
    csr_commit = 0;
    cyc("csr_idle", 5'b0, 5'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a drain.
    set_d(5'd1, 1, 5'd0, 0, 5'd12, 1, 3'd3, 0);
    cyc("ar_prod", 5'b0, 5'b0, 1'b1, 32'h0);
    set_d(5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 1);
    stage_valid = 5'b00100;
    cyc("ar_enter", SRAW, FRAW, 1'b0, 32'h1000);
    cyc("ar_drain", SRAW, FRAW, 1'b0, 32'h1000);
    dec_valid = 0; dec_csr = 0;
    cyc("ar_drain_nod", SRAW, FRAW, 1'b0, 32'h1000);
    resetn = 0;
    cyc("ar_reset", 5'b0, 5'b0, 1'b0, 32'h0);
    resetn = 1;
    cyc("ar_after", 5'b0, 5'b0, 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, want end before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and pipeline-control unit for the in-order core, replacing the fixed 5-stage load-use detector. It keeps a per-register latency scoreboard so producers of any latency (ALU, load, multi-cycle mul/div) stall only dependent consumers. It freezes the pipe on data-memory wait, serialises CSR instructions with a drain state machine, and drives per-stage stall/flush vectors.

## Interface
- `NSTAGE`, default 5: pipeline registers; index 0=F(pc), 1=D, 2=E, 3=M, 4=W.
- `NREG`, default 32: architectural registers; x0 is never tracked.
- `LAT_W`, default 3: width of the latency field and counters.
- `AW`, default `$clog2(NREG)`: register index width.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: D holds a valid instruction.
- `dec_rs1`, `dec_rs2` in AW: sources; `dec_rs1_en`, `dec_rs2_en` in 1: source used.
- `dec_rd` in AW, `dec_wen` in 1: destination and write enable.
- `dec_lat` in LAT_W: bubbles a dependent must wait (0 ALU, 1 load, >1 multi-cycle).
- `dec_csr` in 1: serialising instruction in D.
- `stage_valid` in NSTAGE: per-register valid (non-bubble).
- `csr_commit` in 1: CSR instruction retiring in W.
- `redirect` in 1: jump/branch mispredict resolved in E.
- `trap` in 1: exception or mret taken at W.
- `imem_busy`, `dmem_busy` in 1: memory handshakes not complete.
- `stall` out NSTAGE: register i holds.
- `flush` out NSTAGE: register i loads a bubble.
- `issue` out 1: D instruction enters E this cycle.
- `sb_busy` out NREG: register has nonzero counter.

## Operation
- Scoreboard: counter `cnt[r]` (LAT_W bits) per register; r=0 is hardwired 0.
- On `issue && dec_wen && dec_rd!=0`: `cnt[dec_rd] <= dec_lat`. This write wins over the decrement of the same entry.
- Every cycle without `dmem_busy`: each nonzero counter decrements by 1, saturating at 0.
- `raw = dec_valid && ((dec_rs1_en && cnt[dec_rs1]!=0) || (dec_rs2_en && cnt[dec_rs2]!=0))`.
- CSR FSM (IDLE, DRAIN, WAIT):
  - IDLE -> DRAIN when `dec_valid && dec_csr`.
  - DRAIN -> WAIT when `stage_valid[NSTAGE-1:2]==0` and all counters are 0. The CSR issues in that same cycle.
  - WAIT -> IDLE on `csr_commit`.
  - Any state -> IDLE on `trap`.
- Priority, first match wins; all other stall/flush bits are 0:
  1. `trap`: `flush` all ones; all counters cleared next cycle.
  2. `dmem_busy`: `stall` all ones; counters frozen.
  3. `redirect`: `flush[1]`, `flush[2]`.
  4. `raw`, or DRAIN not yet drained: `stall[0]`, `stall[1]`, `flush[2]`.
  5. WAIT: `stall[0]`, `flush[1]`.
  6. `imem_busy`: `stall[0]`, `flush[1]`.
- `issue = dec_valid && !stall[1] && !flush[2]`, and 0 under trap.

## Timing
- `stall`, `flush`, `issue` are combinational from inputs and state, with no registered latency. `sb_busy` is combinational from the counters.
- Reset (async, `resetn=0`): all counters 0 and FSM IDLE. With idle inputs, all outputs are 0.
- Load (lat 1) followed by a dependent: exactly 1 bubble. Lat N: N bubbles, assuming no `dmem_busy`.
- Reset asserted mid-drain: returns to IDLE immediately with the scoreboard empty.
- `dec_lat` of 0 never stalls.
- Counters saturate and never wrap.

## Test plan
- **Load-use.** Issue load x5 (lat 1), then `add x6,x5,x1`. Required: one cycle with `stall[1:0]=11`, `flush[2]=1`; issue follows next cycle; `sb_busy[5]` is 1 for one cycle.
- **Multi-cycle producer and x0.** Issue a div to x7 with lat 4, then a consumer of x7. Required: 4 stall cycles. Repeat with `dec_rd=0`: required 0 stalls.
- **Memory freeze.** Hold `dmem_busy` for 3 cycles during a lat-2 stall. Required: `stall` all ones for those 3 cycles and the counter frozen; 2 bubbles remain afterwards.
- **Priority.** Assert `redirect` and `raw` together. Required: `flush=00110`, `stall=0`, `issue=0`. Then `trap` with `dmem_busy`: required `flush=11111`, `sb_busy` 0 next cycle.
- **CSR drain.** CSR in D with E/M/W valid. Required: DRAIN stalls until valid bits clear; `issue` 1 for one cycle; WAIT holds `stall[0]=1`, `flush[1]=1` until `csr_commit`; then IDLE.
- **Async reset.** Pulse `resetn` low mid-DRAIN. Required: all outputs 0 and `sb_busy`=0 without a clock edge.
